// File: rtl/shared_mem_responder_pkg.sv
// Shared definitions for the dual-port shared memory responder.
//   state_e          : responder FSM state encoding
//   PORT_A / PORT_B  : port identifiers used for grant and last_grant
//   SHMEM_DATA_W / SHMEM_ADDR_W : default word and address widths
package shmem_pkg;

  localparam int SHMEM_DATA_W = 32;
  localparam int SHMEM_ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/shared_mem_responder_if.sv
// Bus bundle between the two core-side initiators and the shared memory
// responder.
//   req_x/we_x/addr_x/wdata_x : request from initiator x (A = core 1, B = core 2)
//   ack_x/rdata_x             : one-cycle completion pulse and read data
//   busy                      : responder is servicing a transaction
//   wait_cnt_x                : stall-cycle counters (zero unless
//                               SHMEM_WAIT_CNT_EN is defined for the build)
// Modports: master = initiator side, slave = responder side.
interface shared_mem_responder_if #(
  parameter int DATA_W = shmem_pkg::SHMEM_DATA_W,
  parameter int ADDR_W = shmem_pkg::SHMEM_ADDR_W
);
  logic              req_a;
  logic              we_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] wdata_a;
  logic              ack_a;
  logic [DATA_W-1:0] rdata_a;

  logic              req_b;
  logic              we_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_b;
  logic              ack_b;
  logic [DATA_W-1:0] rdata_b;

  logic              busy;
  logic [15:0]       wait_cnt_a;
  logic [15:0]       wait_cnt_b;

  modport master (
    output req_a, we_a, addr_a, wdata_a,
    output req_b, we_b, addr_b, wdata_b,
    input  ack_a, rdata_a, ack_b, rdata_b,
    input  busy, wait_cnt_a, wait_cnt_b
  );

  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    input  req_b, we_b, addr_b, wdata_b,
    output ack_a, rdata_a, ack_b, rdata_b,
    output busy, wait_cnt_a, wait_cnt_b
  );
endinterface

// File: rtl/shared_mem_responder_arb.sv
// Two-way round-robin arbiter, purely combinational.
//   req_a, req_b : pending requests
//   last_grant   : port served most recently (register owned by the caller)
//   gnt          : selected port (PORT_A / PORT_B), meaningful when gnt_valid
//   gnt_valid    : at least one request is pending
module rr_arbiter2
  import shmem_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_grant,
  output logic gnt,
  output logic gnt_valid
);

  always_comb begin
    gnt_valid = req_a | req_b;
    if (req_a && req_b) begin
      // tie: the port that was not served last goes next
      gnt = ~last_grant;
    end else if (req_a) begin
      gnt = PORT_A;
    end else begin
      gnt = PORT_B;
    end
  end

endmodule

// File: rtl/shared_mem_responder.sv
// Shared memory responder: serves core 1 (port A) and core 2 (port B) from a
// single-port word RAM held inside this block. Transactions are strictly
// serial, arbitrated round-robin, and acknowledged two cycles after the
// request is sampled.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : shared_mem_responder_if.slave (requests in, acks/read data out,
//           busy, stall counters)
// Optional feature: define SHMEM_WAIT_CNT_EN to build the per-port
// stall-cycle counters; otherwise wait_cnt_a/b are tied to zero.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | sample requests, latch grant and the granted port's command
// ACCESS | RAM write commits / read data captured for the granted port
// RESP   | one-cycle ack to the granted port, last_grant updated
module shared_mem_responder
  import shmem_pkg::*;
#(
  parameter int DATA_W = SHMEM_DATA_W,
  parameter int ADDR_W = SHMEM_ADDR_W,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic                    clk,
  input  logic                    reset,
  shared_mem_responder_if.slave   bus
);

  state_e            state_q;
  logic              gnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              last_grant_q;
  logic              ack_a_q;
  logic              ack_b_q;
  logic [DATA_W-1:0] rdata_a_q;
  logic [DATA_W-1:0] rdata_b_q;

  logic              arb_gnt;
  logic              arb_valid;

  logic [DATA_W-1:0] mem [DEPTH];

  rr_arbiter2 u_arb (
    .req_a      (bus.req_a),
    .req_b      (bus.req_b),
    .last_grant (last_grant_q),
    .gnt        (arb_gnt),
    .gnt_valid  (arb_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      gnt_q        <= PORT_A;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      last_grant_q <= PORT_B;
      ack_a_q      <= 1'b0;
      ack_b_q      <= 1'b0;
      rdata_a_q    <= '0;
      rdata_b_q    <= '0;
    end else begin
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            gnt_q   <= arb_gnt;
            we_q    <= (arb_gnt == PORT_A) ? bus.we_a    : bus.we_b;
            addr_q  <= (arb_gnt == PORT_A) ? bus.addr_a  : bus.addr_b;
            wdata_q <= (arb_gnt == PORT_A) ? bus.wdata_a : bus.wdata_b;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (!we_q) begin
            if (gnt_q == PORT_A) rdata_a_q <= mem[addr_q];
            else                 rdata_b_q <= mem[addr_q];
          end
          // ack is registered here so it is high exactly during RESP
          if (gnt_q == PORT_A) ack_a_q <= 1'b1;
          else                 ack_b_q <= 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          last_grant_q <= gnt_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // RAM write port, kept free of reset so the array infers as plain memory;
  // reset still blocks a write that is in flight.
  always_ff @(posedge clk) begin
    if (!reset && state_q == ACCESS && we_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

  // A reset raised during RESP must hide the ack that is already registered.
  assign bus.ack_a   = ack_a_q & ~reset;
  assign bus.ack_b   = ack_b_q & ~reset;
  assign bus.rdata_a = rdata_a_q;
  assign bus.rdata_b = rdata_b_q;
  assign bus.busy    = (state_q != IDLE);

`ifdef SHMEM_WAIT_CNT_EN
  logic [15:0] wait_a_q;
  logic [15:0] wait_b_q;
  logic        in_service;

  assign in_service = (state_q == ACCESS) || (state_q == RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_a_q <= '0;
      wait_b_q <= '0;
    end else begin
      if (bus.req_a && in_service && gnt_q != PORT_A && wait_a_q != 16'hFFFF)
        wait_a_q <= wait_a_q + 16'd1;
      if (bus.req_b && in_service && gnt_q != PORT_B && wait_b_q != 16'hFFFF)
        wait_b_q <= wait_b_q + 16'd1;
    end
  end

  assign bus.wait_cnt_a = wait_a_q;
  assign bus.wait_cnt_b = wait_b_q;
`else
  assign bus.wait_cnt_a = '0;
  assign bus.wait_cnt_b = '0;
`endif

endmodule

// File: tb/tb_shared_mem_responder.sv
// Randomised self-checking bench for shared_mem_responder. The reference
// model works per transaction: service order from the round-robin rule,
// memory contents in a plain array, expected ack timing as cycle offsets.
module tb_shared_mem_responder;

`ifdef SHMEM_WAIT_CNT_EN
  localparam bit WC_EN = 1'b1;
`else
  localparam bit WC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;

  shared_mem_responder_if bus ();

  shared_mem_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] mm [1024];
  logic [31:0] exp_rd [2];
  int          wc [2];
  int          last_g;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic int sat_add2(input int v);
    return (v + 2 > 65535) ? 65535 : v + 2;
  endfunction

  task automatic model_reset();
    last_g    = 1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    wc[0]     = 0;
    wc[1]     = 0;
  endtask

  task automatic model_serve(input int p, input bit w, input logic [9:0] a, input logic [31:0] d);
    if (w) mm[a] = d;
    else   exp_rd[p] = mm[a];
    last_g = p;
  endtask

  task automatic chk_waits(input string tag);
    chk({tag, "_wait_a"}, {16'h0, bus.wait_cnt_a}, WC_EN ? wc[0] : 0);
    chk({tag, "_wait_b"}, {16'h0, bus.wait_cnt_b}, WC_EN ? wc[1] : 0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ack_a"},   {31'h0, bus.ack_a}, 32'h0);
    chk({tag, "_ack_b"},   {31'h0, bus.ack_b}, 32'h0);
    chk({tag, "_busy"},    {31'h0, bus.busy},  32'h0);
    chk({tag, "_rdata_a"}, bus.rdata_a, exp_rd[0]);
    chk({tag, "_rdata_b"}, bus.rdata_b, exp_rd[1]);
    chk_waits(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Called at a negedge with the responder idle. Presents one request per
  // enabled port in the same cycle, then waits for the acks.
  task automatic run_pair(input bit en_a, input bit w_a, input logic [9:0] a_a, input logic [31:0] d_a,
                          input bit en_b, input bit w_b, input logic [9:0] a_b, input logic [31:0] d_b);
    bit          en [2];
    bit          w  [2];
    logic [9:0]  ad [2];
    logic [31:0] wd [2];
    int          exp_t [2];
    int          t [2];
    int          nack [2];
    int          first;
    int          cyc;
    en[0] = en_a; w[0] = w_a; ad[0] = a_a; wd[0] = d_a;
    en[1] = en_b; w[1] = w_b; ad[1] = a_b; wd[1] = d_b;
    if (en[0] && en[1]) first = (last_g == 1) ? 0 : 1;
    else                first = en[0] ? 0 : 1;
    model_serve(first, w[first], ad[first], wd[first]);
    exp_t[first] = 2;
    if (en[1-first]) begin
      wc[1-first] = sat_add2(wc[1-first]);
      model_serve(1-first, w[1-first], ad[1-first], wd[1-first]);
      exp_t[1-first] = 5;
    end
    t[0] = -1; t[1] = -1; nack[0] = 0; nack[1] = 0; cyc = 0;
    bus.req_a = en[0]; bus.we_a = w[0]; bus.addr_a = ad[0]; bus.wdata_a = wd[0];
    bus.req_b = en[1]; bus.we_b = w[1]; bus.addr_b = ad[1]; bus.wdata_b = wd[1];
    while (cyc < 20 && ((en[0] && t[0] < 0) || (en[1] && t[1] < 0))) begin
      @(negedge clk);
      cyc++;
      if (bus.ack_a) begin
        nack[0]++;
        if (t[0] < 0) begin
          t[0] = cyc;
          chk("pair_rdata_a", bus.rdata_a, exp_rd[0]);
          bus.req_a = 1'b0;
        end
      end
      if (bus.ack_b) begin
        nack[1]++;
        if (t[1] < 0) begin
          t[1] = cyc;
          chk("pair_rdata_b", bus.rdata_b, exp_rd[1]);
          bus.req_b = 1'b0;
        end
      end
    end
    @(negedge clk);
    if (bus.ack_a) nack[0]++;
    if (bus.ack_b) nack[1]++;
    if (en[0]) chk("pair_lat_a", t[0], exp_t[0]);
    if (en[1]) chk("pair_lat_b", t[1], exp_t[1]);
    chk("pair_nack_a", nack[0], {31'h0, en[0]});
    chk("pair_nack_b", nack[1], {31'h0, en[1]});
    chk("pair_busy", {31'h0, bus.busy}, 32'h0);
    chk("pair_rdata_a_end", bus.rdata_a, exp_rd[0]);
    chk("pair_rdata_b_end", bus.rdata_b, exp_rd[1]);
    chk_waits("pair");
  endtask

  // Both ports issue back-to-back reads, n each; a port drops req after its
  // last ack. Grants must alternate with a 3-cycle ack spacing.
  task automatic run_stream(input int n);
    logic [9:0] ad [2];
    int left [2];
    int exp_p;
    int prev;
    int cyc;
    int got;
    int p;
    left[0] = n; left[1] = n;
    exp_p = (last_g == 1) ? 0 : 1;
    prev = 0; cyc = 0; got = 0;
    ad[0] = 10'($urandom_range(0, 31));
    ad[1] = 10'($urandom_range(0, 31));
    bus.we_a = 1'b0; bus.addr_a = ad[0]; bus.req_a = 1'b1;
    bus.we_b = 1'b0; bus.addr_b = ad[1]; bus.req_b = 1'b1;
    while (got < 2 * n && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (bus.ack_a || bus.ack_b) begin
        p = bus.ack_a ? 0 : 1;
        if (bus.ack_a) chk("stream_single_ack", {31'h0, bus.ack_b}, 32'h0);
        chk("stream_order", p, exp_p);
        chk("stream_gap", cyc - prev, (got == 0) ? 2 : 3);
        model_serve(p, 1'b0, ad[p], 32'h0);
        chk("stream_rdata", p == 0 ? bus.rdata_a : bus.rdata_b, exp_rd[p]);
        left[p]--;
        if (left[1-p] > 0) wc[1-p] = sat_add2(wc[1-p]);
        ad[p] = 10'($urandom_range(0, 31));
        if (p == 0) begin bus.addr_a = ad[0]; bus.req_a = (left[0] > 0); end
        else        begin bus.addr_b = ad[1]; bus.req_b = (left[1] > 0); end
        exp_p = (left[1-p] > 0) ? 1 - p : p;
        prev = cyc;
        got++;
      end
    end
    chk("stream_count", got, 2 * n);
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    @(negedge clk);
    chk("stream_busy", {31'h0, bus.busy}, 32'h0);
    chk_waits("stream");
  endtask

  initial begin
    bus.req_a = 1'b0; bus.we_a = 1'b0; bus.addr_a = '0; bus.wdata_a = '0;
    bus.req_b = 1'b0; bus.we_b = 1'b0; bus.addr_b = '0; bus.wdata_b = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_idle("reset");

    // fill the working window so every later read has known data
    for (int i = 0; i < 32; i++) begin
      if (i % 2 == 0) run_pair(1'b1, 1'b1, 10'(i), $urandom, 1'b0, 1'b0, '0, '0);
      else            run_pair(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 10'(i), $urandom);
    end

    // single A write then read back
    do_reset();
    run_pair(1'b1, 1'b1, 10'h005, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0);
    run_pair(1'b1, 1'b0, 10'h005, 32'h0, 1'b0, 1'b0, '0, '0);
    chk("a_read_deadbeef", bus.rdata_a, 32'hDEADBEEF);

    // simultaneous A write / B read of the same word after reset
    do_reset();
    run_pair(1'b1, 1'b1, 10'h010, 32'h1, 1'b1, 1'b0, 10'h010, 32'h0);
    chk("b_sees_a_write", bus.rdata_b, 32'h1);

    // continuous contention
    run_stream(4);

    // reset during ACCESS of a B write
    run_pair(1'b1, 1'b1, 10'h3FF, 32'h0, 1'b0, 1'b0, '0, '0);
    bus.req_b = 1'b1; bus.we_b = 1'b1; bus.addr_b = 10'h3FF; bus.wdata_b = 32'hCAFE0001;
    @(negedge clk);
    reset = 1'b1;
    bus.req_b = 1'b0;
    @(negedge clk);
    chk("rst_access_ack_b", {31'h0, bus.ack_b}, 32'h0);
    chk("rst_access_busy", {31'h0, bus.busy}, 32'h0);
    reset = 1'b0;
    model_reset();
    chk_idle("rst_access");
    run_pair(1'b1, 1'b0, 10'h3FF, 32'h0, 1'b0, 1'b0, '0, '0);
    chk("rst_access_no_commit", bus.rdata_a, 32'h0);

    // write ack must leave earlier read data in place
    run_pair(1'b1, 1'b1, 10'h007, 32'h12345678, 1'b0, 1'b0, '0, '0);
    run_pair(1'b1, 1'b0, 10'h007, 32'h0, 1'b0, 1'b0, '0, '0);
    run_pair(1'b1, 1'b1, 10'h008, 32'h0, 1'b0, 1'b0, '0, '0);
    chk("rdata_a_hold", bus.rdata_a, 32'h12345678);

    // reset during RESP hides the ack
    bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = 10'h007;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_resp_ack_a", {31'h0, bus.ack_a}, 32'h0);
    bus.req_a = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk_idle("rst_resp");

    // randomised traffic
    for (int i = 0; i < 60; i++) begin
      bit ea, eb;
      ea = 1'($urandom_range(0, 1));
      eb = 1'($urandom_range(0, 1));
      if (!ea && !eb) ea = 1'b1;
      run_pair(ea, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 31)), $urandom,
               eb, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 31)), $urandom);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

endmodule
